// File: rtl/serial_frame_receiver.sv
// Bit-serial frame receiver: hunts for a sync word, deserializes an MSB-first
// payload, checks a trailing even-parity bit and counts good and bad frames.
module serial_frame_receiver #(
    parameter int                SYNC_W    = 4,
    parameter logic [SYNC_W-1:0] SYNC_WORD = 4'b1011,
    parameter int                DATA_W    = 8,
    parameter int                CNT_W     = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              input_data,
    output logic [DATA_W-1:0] output_data,
    output logic              data_valid,
    output logic              parity_err,
    output logic              sync_lock,
    output logic [CNT_W-1:0]  frame_count,
    output logic [CNT_W-1:0]  err_count
);

    localparam int FILL_W = $clog2(SYNC_W + 1);
    localparam int BIT_W  = $clog2(DATA_W);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SYNC_W - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [SYNC_W-1:0] r_window;
    logic [SYNC_W-1:0] w_nextWindow;
    logic [FILL_W-1:0] r_fill;
    logic [BIT_W-1:0]  r_bitCnt;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_outData;
    logic              r_dataValid;
    logic              r_parityErr;
    logic              r_syncLock;
    logic [CNT_W-1:0]  r_frameCount;
    logic [CNT_W-1:0]  r_errCount;
    logic              w_match;
    logic              w_parityErr;

    // The fill guard keeps a stale or cleared window from matching before a
    // full sync word has arrived since (re)entering the hunt.
    assign w_nextWindow = {r_window[SYNC_W-2:0], input_data};
    assign w_match      = (w_nextWindow == SYNC_WORD) && (r_fill >= FILL_LAST);
    assign w_parityErr  = (^r_data) ^ input_data;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            HUNT: begin
                if (w_match) begin
                    w_nextState = DATA;
                end
            end
            DATA: begin
                if (r_bitCnt == BIT_LAST) begin
                    w_nextState = PARITY;
                end
            end
            PARITY: begin
                w_nextState = HUNT;
            end
            default: begin
                w_nextState = HUNT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_window     <= '0;
            r_fill       <= '0;
            r_bitCnt     <= '0;
            r_data       <= '0;
            r_outData    <= '0;
            r_dataValid  <= 1'b0;
            r_parityErr  <= 1'b0;
            r_syncLock   <= 1'b0;
            r_frameCount <= '0;
            r_errCount   <= '0;
        end else begin
            r_dataValid <= 1'b0;
            r_syncLock  <= (w_nextState != HUNT);
            case (r_state)
                HUNT: begin
                    r_window <= w_nextWindow;
                    r_bitCnt <= '0;
                    if (r_fill != FILL_FULL) begin
                        r_fill <= r_fill + FILL_W'(1);
                    end
                end
                DATA: begin
                    r_data   <= {r_data[DATA_W-2:0], input_data};
                    r_bitCnt <= r_bitCnt + BIT_W'(1);
                end
                PARITY: begin
                    r_outData   <= r_data;
                    r_dataValid <= 1'b1;
                    r_parityErr <= w_parityErr;
                    r_window    <= '0;
                    r_fill      <= '0;
                    if (w_parityErr) begin
                        r_errCount <= r_errCount + CNT_W'(1);
                    end else begin
                        r_frameCount <= r_frameCount + CNT_W'(1);
                    end
                end
                default: begin
                    r_window <= '0;
                    r_fill   <= '0;
                end
            endcase
        end
    end

    assign output_data = r_outData;
    assign data_valid  = r_dataValid;
    assign parity_err  = r_parityErr;
    assign sync_lock   = r_syncLock;
    assign frame_count = r_frameCount;
    assign err_count   = r_errCount;

endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Bit-serial frame receiver that sits directly downstream of the 4-stage DFF link chain and consumes its one-bit `output_data` stream, one bit per `CLK` rising edge. It hunts for a fixed sync word, then deserializes a fixed-width data word MSB-first and checks a trailing even-parity bit. It presents each received word with a one-cycle valid pulse and keeps counts of good and bad frames.

## Interface
- `SYNC_W`, default 4: sync word width in bits, ≥2.
- `SYNC_WORD`, default 4'b1011: sync pattern, MSB received first.
- `DATA_W`, default 8: payload width in bits, ≥2.
- `CNT_W`, default 8: width of both frame counters.
- `CLK` in 1: single clock; everything samples on the rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `input_data` in 1: serial bit stream, sampled every rising edge (no enable).
- `output_data` out DATA_W: last received payload, held until the next frame completes.
- `data_valid` out 1: one-cycle pulse; `output_data` and `parity_err` are new in this cycle.
- `parity_err` out 1: parity result of the last frame, held.
- `sync_lock` out 1: high while in DATA or PARITY state.
- `frame_count` out CNT_W: number of good-parity frames; wraps modulo 2^CNT_W.
- `err_count` out CNT_W: number of bad-parity frames; wraps modulo 2^CNT_W.

## Operation
- State machine states:
  - HUNT (reset state):
    - Shift `input_data` into an SYNC_W-bit window, LSB end: window <= {window[SYNC_W-2:0], input_data}.
    - A fill counter saturates at SYNC_W and is cleared on entry to HUNT.
    - A match is the next window value equal to SYNC_WORD with at least SYNC_W bits shifted since entry, counting the current bit.
    - On a match: go to DATA and clear the bit counter.
    - Overlapping prefixes must be handled as a sliding window (e.g., 1 1 0 1 1 matches on the 5th bit).
  - DATA:
    - Shift bits MSB-first into the data register.
    - The bit counter runs 0..DATA_W-1.
    - On the edge that samples bit DATA_W-1, go to PARITY.
    - Sync patterns inside the payload are ignored.
  - PARITY:
    - Sample the parity bit.
    - err = XOR(data bits) XOR parity bit; even parity is required.
    - On the same edge:
      - `output_data` <= data register.
      - `data_valid` <= 1.
      - `parity_err` <= err.
      - If err, increment `err_count`; otherwise increment `frame_count`.
    - Next state is HUNT, with the fill counter and window cleared.
- Frame length is SYNC_W + DATA_W + 1 bits. Back-to-back frames with no idle bits must all be received.
- No framing recovery: after PARITY the block always re-hunts. A bad-parity payload is still presented, with `parity_err` = 1.

## Timing
- Reset (RST low, asynchronous assert):
  - state = HUNT.
  - `output_data`, `data_valid`, `parity_err`, `sync_lock`, `frame_count`, `err_count`, window, and fill and bit counters all go to 0.
- Reset release takes effect at the next rising edge with RST high.
- Reset mid-frame aborts the frame: no `data_valid` and no counter change.
- Latency: `data_valid` is registered. It is high for exactly the one cycle after the edge that samples the parity bit, i.e. the edge SYNC_W+DATA_W+1 bits after the first sync bit.
- Valid spacing: `data_valid` is never high on consecutive cycles. The minimum spacing is SYNC_W+DATA_W+1 cycles.
- `sync_lock`:
  - Rises in the cycle after the sync match edge.
  - Falls in the same cycle that `data_valid` rises.
- Held outputs: `output_data` and `parity_err` change only on a `data_valid` cycle.
- Counter wrap: counters wrap silently, e.g. 8'hFF + 1 = 8'h00.

## Test plan
All scenarios use the default parameters; bits are listed in arrival order.
- **Good frame:** reset, then stream 1011, 10100101, 0 -> `output_data` = 8'hA5, `data_valid` high for 1 cycle, `parity_err` = 0, `frame_count` = 1, `err_count` = 0.
- **Parity error:** stream 1011, 00111100, 1 -> `output_data` = 8'h3C, `parity_err` = 1, `err_count` = 1, `frame_count` unchanged.
- **Back-to-back and embedded sync:**
  - Stream 1011, 10110000, 1 then immediately 1011, 11111111, 0.
  - Expect two valid pulses 13 cycles apart, with 8'hB0 then 8'hFF and no errors.
  - The payload 1011 must not resync.
- **Hunt robustness:**
  - 200 cycles with no 1011 window (e.g. all zeros, or repeating 1001) -> no `data_valid`, `sync_lock` stays 0.
  - Then stream 11011 + 8'h5A + 0 -> sync on the 5th bit, `output_data` = 8'h5A.
- **Reset mid-frame:**
  - Assert RST low between rising edges after 6 payload bits.
  - Expect all outputs 0 immediately, with no valid pulse.
  - After release, a full good frame is received normally.
- **Counter wrap:** 256 good frames -> `frame_count` returns to 0.
